pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the load-use hazard interface: takes pc_write / IFID_write / nop_control from the
//  hazard detection unit plus branch-resolve and external-stall inputs, and owns the PC, IF/ID and
//  ID/EX-control pipeline registers. Applies freezes, bubble insertion and branch flushes, keeps stall
//  statistics and flags stuck stalls. Sits between instruction fetch and the ID/EX register of the 8-bit core.
// PARAMETERS
//  PC_W        8   PC / instruction-address width
//  INSTR_W     32  instruction word width held in IF/ID
//  CTRL_W      9   width of decoded control bundle entering ID/EX
//  FLUSH_CYC   1   bubble cycles inserted after a taken branch (1..3)
//  MAX_STALL   4   consecutive load-use stall cycles tolerated before stall_err
//  CNT_W       16  statistics counter width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        synchronous reset, active low
//  pc_write       in   1        hazard unit: 0 = hold PC
//  IFID_write     in   1        hazard unit: 0 = hold IF/ID
//  nop_control    in   1        hazard unit: 1 = bubble into ID/EX
//  ext_stall      in   1        memory not ready: freeze all three registers
//  branch_taken   in   1        branch resolved taken this cycle
//  branch_target  in   PC_W     redirect address
//  if_instr       in   INSTR_W  fetched instruction at pc
//  id_ctrl        in   CTRL_W   decoder control for instruction in IF/ID
//  pc             out  PC_W     current fetch address
//  ifid_instr     out  INSTR_W  IF/ID instruction
//  ifid_pc        out  PC_W     IF/ID PC
//  ifid_valid     out  1        IF/ID holds a real instruction
//  idex_ctrl      out  CTRL_W   ID/EX control (all-zero = NOP)
//  idex_valid     out  1        ID/EX holds a real instruction
//  stall_cnt      out  CNT_W    load-use stall cycles, saturating
//  flush_cnt      out  CNT_W    branch flushes, saturating
//  stall_err      out  1        sticky: stall exceeded MAX_STALL
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): pc=0, ifid_*=0, ifid_valid=0, idex_ctrl=0, idex_valid=0, counters=0,
//   stall_err=0, state=RUN, flush/stall counters cleared. Reset mid-flush or mid-stall aborts it.
//  Priority per edge: reset > ext_stall > branch_taken > load-use stall > normal advance.
//  ext_stall=1: pc, IF/ID, ID/EX, state, counters all hold; branch_taken is ignored (source must hold it).
//  FSM states RUN, STALL, FLUSH:
//   RUN: advance pc=pc+1 (wraps 2^PC_W-1 -> 0); IF/ID <= {if_instr,pc,1}; ID/EX <= {id_ctrl,ifid_valid}.
//   nop_control=1 (in RUN/STALL, no branch): ID/EX <= 0/valid 0; pc held iff pc_write=0; IF/ID held iff
//    IFID_write=0 (signals honoured independently); stall_cnt++ ; state -> STALL.
//   STALL: consecutive-stall counter increments; when it would exceed MAX_STALL set stall_err (sticky);
//    nop_control=0 -> RUN, counter cleared, normal advance same edge.
//   branch_taken=1 (any state): pc <= branch_target; IF/ID <= 0, ifid_valid=0; ID/EX <= 0; flush_cnt++;
//    overrides nop_control/pc_write; state -> FLUSH with FLUSH_CYC-1 remaining (FLUSH_CYC=1 -> RUN).
//   FLUSH: pc advances, IF/ID loads normally, ID/EX forced NOP; decrement; at 0 -> RUN. A new
//    branch_taken in FLUSH restarts the flush.
//  Counters saturate at all-ones, never wrap. Latency: all outputs registered, 1 cycle from inputs.
// STRUCTURE
//  Package pipe_ctrl_pkg: state enum (RUN/STALL/FLUSH), NOP control constant (CTRL_W'0), reset PC.
//  One sub-module: sat_counter (parameter W; inc, clr, q) instanced for stall_cnt and flush_cnt.
//  FSM, PC and pipeline registers in the top.
// TESTING
//  Reset: hold rst_n=0 2 cycles with random inputs -> all outputs 0; release -> pc 0,1,2 on next edges.
//  Load-use: nop_control=1,pc_write=0,IFID_write=0 for 1 cycle at pc=5 -> pc stays 5, idex_ctrl=0,
//   idex_valid=0, IF/ID unchanged, stall_cnt=1; then pc=6.
//  Branch: branch_taken with target 8'h40 at pc=0x12, FLUSH_CYC=2 -> pc=0x40, ifid_valid=0, two NOP
//   cycles in ID/EX, flush_cnt=1; branch same cycle as nop_control -> branch wins, stall_cnt unchanged.
//  ext_stall: assert 3 cycles mid-FLUSH -> every output frozen, flush resumes with same remaining count.
//  Watchdog: nop_control held 5 cycles, MAX_STALL=4 -> stall_err=1 on 5th edge, stays 1 after release.
//  Wrap/saturate: pc=8'hFF advance -> 8'h00; force stall_cnt to 16'hFFFF, stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller.
//   pipe_state_e : controller operating mode (RUN / STALL / FLUSH)
//   NOP_CTRL     : control bundle value meaning "no operation" in ID/EX
//   RESET_PC     : fetch address after reset
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } pipe_state_e;

   localparam int unsigned NOP_CTRL = 0;
   localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Bundles the hazard-unit, branch, fetch and decode signals going into the
// stall controller together with the pipeline-register outputs it owns.
//   master : hazard unit / fetch / decode side (drives requests, sees regs)
//   slave  : the stall controller itself
// Inputs to controller : pc_write, IFID_write, nop_control, ext_stall,
//                        branch_taken, branch_target, if_instr, id_ctrl
// Outputs of controller: pc, ifid_instr, ifid_pc, ifid_valid, idex_ctrl,
//                        idex_valid, stall_cnt, flush_cnt, stall_err
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32,
   parameter int CTRL_W  = 9,
   parameter int CNT_W   = 16
);

   logic               pc_write;
   logic               IFID_write;
   logic               nop_control;
   logic               ext_stall;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [INSTR_W-1:0] if_instr;
   logic [CTRL_W-1:0]  id_ctrl;

   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0]    ifid_pc;
   logic               ifid_valid;
   logic [CTRL_W-1:0]  idex_ctrl;
   logic               idex_valid;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;
   logic               stall_err;

   modport master (
      output pc_write, IFID_write, nop_control, ext_stall, branch_taken,
             branch_target, if_instr, id_ctrl,
      input  pc, ifid_instr, ifid_pc, ifid_valid, idex_ctrl, idex_valid,
             stall_cnt, flush_cnt, stall_err
   );

   modport slave (
      input  pc_write, IFID_write, nop_control, ext_stall, branch_taken,
             branch_target, if_instr, id_ctrl,
      output pc, ifid_instr, ifid_pc, ifid_valid, idex_ctrl, idex_valid,
             stall_cnt, flush_cnt, stall_err
   );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk : rising-edge clock
//   clr : synchronous clear (wins over inc)
//   inc : count one event this edge
//   q   : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] count_q;

   // Count register: clear has priority, and once all-ones is reached further
   // events are dropped so a long run of stalls never reads back as small.
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign q = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Owns the PC, IF/ID and ID/EX-control registers of the 8-bit core and
// applies load-use freezes, bubble insertion, branch flushes and memory
// stalls to them. Keeps saturating stall/flush statistics and raises a
// sticky error when a load-use stall lasts longer than MAX_STALL cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : pipeline_stall_ctrl_if.slave (hazard/branch/fetch/decode inputs,
//           pipeline register and statistics outputs)
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int INSTR_W   = 32,
   parameter int CTRL_W    = 9,
   parameter int FLUSH_CYC = 1,
   parameter int MAX_STALL = 4,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_stall_ctrl_if.slave  bus
);

   localparam int SW = $clog2(MAX_STALL + 2);
   localparam logic [SW-1:0] STALL_LIMIT  = SW'(MAX_STALL);
   localparam logic [SW-1:0] STALL_SAT    = SW'(MAX_STALL + 1);
   localparam logic [1:0]    FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
   localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(NOP_CTRL);
   localparam logic [PC_W-1:0]   PC_RESET = PC_W'(RESET_PC);

   pipe_state_e        state_q,      state_d;
   logic [1:0]         flush_rem_q,  flush_rem_d;
   logic [SW-1:0]      stall_run_q,  stall_run_d;
   logic [SW-1:0]      stall_run_inc;
   logic               stall_err_q,  stall_err_d;
   logic [PC_W-1:0]    pc_q,         pc_d;
   logic [PC_W-1:0]    pc_plus1;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q,    ifid_pc_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0]  idex_ctrl_q,  idex_ctrl_d;
   logic               idex_valid_q, idex_valid_d;
   logic               stall_inc;
   logic               flush_inc;

   assign pc_plus1      = pc_q + PC_W'(1);
   assign stall_run_inc = (stall_run_q == STALL_SAT) ? stall_run_q : stall_run_q + SW'(1);

   // Next-state and next-register logic. Everything defaults to "hold", which
   // is exactly what a memory stall needs. A taken branch beats any load-use
   // request; FLUSH ignores the hazard unit because the instructions it would
   // protect are already being squashed. The consecutive-stall run saturates
   // one past the limit so the comparison stays valid however long it lasts.
   always_comb begin
      state_d      = state_q;
      flush_rem_d  = flush_rem_q;
      stall_run_d  = stall_run_q;
      stall_err_d  = stall_err_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      idex_ctrl_d  = idex_ctrl_q;
      idex_valid_d = idex_valid_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      if (bus.ext_stall) begin
         state_d = state_q;
      end else if (bus.branch_taken) begin
         pc_d         = bus.branch_target;
         ifid_instr_d = '0;
         ifid_pc_d    = '0;
         ifid_valid_d = 1'b0;
         idex_ctrl_d  = CTRL_NOP;
         idex_valid_d = 1'b0;
         flush_inc    = 1'b1;
         stall_run_d  = '0;
         if (FLUSH_RELOAD != 2'd0) begin
            state_d     = ST_FLUSH;
            flush_rem_d = FLUSH_RELOAD;
         end else begin
            state_d     = ST_RUN;
            flush_rem_d = 2'd0;
         end
      end else begin
         case (state_q)
            ST_FLUSH: begin
               pc_d         = pc_plus1;
               ifid_instr_d = bus.if_instr;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
               idex_ctrl_d  = CTRL_NOP;
               idex_valid_d = 1'b0;
               if (flush_rem_q <= 2'd1) begin
                  state_d     = ST_RUN;
                  flush_rem_d = 2'd0;
               end else begin
                  flush_rem_d = flush_rem_q - 2'd1;
               end
            end
            default: begin
               if (bus.nop_control) begin
                  idex_ctrl_d  = CTRL_NOP;
                  idex_valid_d = 1'b0;
                  if (bus.pc_write) begin
                     pc_d = pc_plus1;
                  end
                  if (bus.IFID_write) begin
                     ifid_instr_d = bus.if_instr;
                     ifid_pc_d    = pc_q;
                     ifid_valid_d = 1'b1;
                  end
                  stall_inc   = 1'b1;
                  stall_run_d = stall_run_inc;
                  if (stall_run_inc > STALL_LIMIT) begin
                     stall_err_d = 1'b1;
                  end
                  state_d = ST_STALL;
               end else begin
                  pc_d         = pc_plus1;
                  ifid_instr_d = bus.if_instr;
                  ifid_pc_d    = pc_q;
                  ifid_valid_d = 1'b1;
                  idex_ctrl_d  = bus.id_ctrl;
                  idex_valid_d = ifid_valid_q;
                  stall_run_d  = '0;
                  state_d      = ST_RUN;
               end
            end
         endcase
      end
   end

   // State and pipeline registers. Reset drops any flush or stall in progress
   // and restarts fetch from the reset PC with empty pipeline stages.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         flush_rem_q  <= 2'd0;
         stall_run_q  <= '0;
         stall_err_q  <= 1'b0;
         pc_q         <= PC_RESET;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         idex_ctrl_q  <= CTRL_NOP;
         idex_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_rem_q  <= flush_rem_d;
         stall_run_q  <= stall_run_d;
         stall_err_q  <= stall_err_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         idex_ctrl_q  <= idex_ctrl_d;
         idex_valid_q <= idex_valid_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (~rst_n),
      .inc (stall_inc),
      .q   (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (~rst_n),
      .inc (flush_inc),
      .q   (bus.flush_cnt)
   );

   assign bus.pc         = pc_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.ifid_pc    = ifid_pc_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.idex_ctrl  = idex_ctrl_q;
   assign bus.idex_valid = idex_valid_q;
   assign bus.stall_err  = stall_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Self-checking bench for pipeline_stall_ctrl (FLUSH_CYC=2, MAX_STALL=4).
// A behavioural model tracks the expected pipeline contents; after every
// clock edge all outputs are compared against it, and directed steps add
// explicit checks on reset, load-use, branch, memory stall, watchdog, PC
// wrap and counter saturation. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

   localparam int PC_W      = 8;
   localparam int INSTR_W   = 32;
   localparam int CTRL_W    = 9;
   localparam int FLUSH_CYC = 2;
   localparam int MAX_STALL = 4;
   localparam int CNT_W     = 16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pipeline_stall_ctrl_if #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) bus ();

   pipeline_stall_ctrl #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W),
      .FLUSH_CYC(FLUSH_CYC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [PC_W-1:0]    m_pc;
   logic [INSTR_W-1:0] m_ifid_instr;
   logic [PC_W-1:0]    m_ifid_pc;
   logic               m_ifid_valid;
   logic [CTRL_W-1:0]  m_idex_ctrl;
   logic               m_idex_valid;
   logic [CNT_W-1:0]   m_stall_cnt;
   logic [CNT_W-1:0]   m_flush_cnt;
   logic               m_err;
   int                 m_bubbles;
   int                 m_streak;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one clock edge, from the rules: reset, memory stall, taken
   // branch, pending flush bubbles, load-use stall, plain advance.
   task automatic modelStep();
      logic [PC_W-1:0] old_pc;
      logic            old_valid;
      old_pc    = m_pc;
      old_valid = m_ifid_valid;
      if (!rst_n) begin
         m_pc = '0; m_ifid_instr = '0; m_ifid_pc = '0; m_ifid_valid = 1'b0;
         m_idex_ctrl = '0; m_idex_valid = 1'b0; m_stall_cnt = '0;
         m_flush_cnt = '0; m_err = 1'b0; m_bubbles = 0; m_streak = 0;
      end else if (bus.ext_stall) begin
         m_bubbles = m_bubbles;
      end else if (bus.branch_taken) begin
         m_pc = bus.branch_target;
         m_ifid_instr = '0; m_ifid_pc = '0; m_ifid_valid = 1'b0;
         m_idex_ctrl = '0; m_idex_valid = 1'b0;
         if (m_flush_cnt != 16'hFFFF) m_flush_cnt = m_flush_cnt + 1;
         m_bubbles = FLUSH_CYC - 1;
         m_streak  = 0;
      end else if (m_bubbles > 0) begin
         m_ifid_instr = bus.if_instr; m_ifid_pc = old_pc; m_ifid_valid = 1'b1;
         m_pc = old_pc + 8'd1;
         m_idex_ctrl = '0; m_idex_valid = 1'b0;
         m_bubbles = m_bubbles - 1;
      end else if (bus.nop_control) begin
         m_idex_ctrl = '0; m_idex_valid = 1'b0;
         if (bus.pc_write) m_pc = old_pc + 8'd1;
         if (bus.IFID_write) begin
            m_ifid_instr = bus.if_instr; m_ifid_pc = old_pc; m_ifid_valid = 1'b1;
         end
         if (m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 1;
         m_streak = m_streak + 1;
         if (m_streak > MAX_STALL) m_err = 1'b1;
      end else begin
         m_idex_ctrl = bus.id_ctrl; m_idex_valid = old_valid;
         m_ifid_instr = bus.if_instr; m_ifid_pc = old_pc; m_ifid_valid = 1'b1;
         m_pc = old_pc + 8'd1;
         m_streak = 0;
      end
   endtask

   task automatic checkOutput();
      checkVal("pc",         bus.pc,         m_pc);
      checkVal("ifid_instr", bus.ifid_instr, m_ifid_instr);
      checkVal("ifid_pc",    bus.ifid_pc,    m_ifid_pc);
      checkVal("ifid_valid", bus.ifid_valid, m_ifid_valid);
      checkVal("idex_ctrl",  bus.idex_ctrl,  m_idex_ctrl);
      checkVal("idex_valid", bus.idex_valid, m_idex_valid);
      checkVal("stall_cnt",  bus.stall_cnt,  m_stall_cnt);
      checkVal("flush_cnt",  bus.flush_cnt,  m_flush_cnt);
      checkVal("stall_err",  bus.stall_err,  m_err);
   endtask

   task automatic applyStimulus(input logic rst_v, input logic ext, input logic br,
                                input logic nop, input logic pcw, input logic ifw,
                                input logic [PC_W-1:0] tgt);
      rst_n             = rst_v;
      bus.ext_stall     = ext;
      bus.branch_taken  = br;
      bus.nop_control   = nop;
      bus.pc_write      = pcw;
      bus.IFID_write    = ifw;
      bus.branch_target = tgt;
      bus.if_instr      = $urandom;
      bus.id_ctrl       = CTRL_W'($urandom);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   logic [INSTR_W-1:0] snap_instr;
   logic [PC_W-1:0]    snap_pc;
   logic [PC_W-1:0]    snap_ifid_pc;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_pc = '0; m_ifid_instr = '0; m_ifid_pc = '0; m_ifid_valid = 1'b0;
      m_idex_ctrl = '0; m_idex_valid = 1'b0; m_stall_cnt = '0;
      m_flush_cnt = '0; m_err = 1'b0; m_bubbles = 0; m_streak = 0;

      // Reset held two cycles with random side inputs.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 8'($urandom));
         stepCycle();
      end
      checkVal("rst_pc",        bus.pc,         8'h00);
      checkVal("rst_ifid_valid",bus.ifid_valid, 1'b0);
      checkVal("rst_idex_ctrl", bus.idex_ctrl,  9'h000);
      checkVal("rst_stall_cnt", bus.stall_cnt,  16'h0000);
      checkVal("rst_err",       bus.stall_err,  1'b0);

      // Release: pc runs 1, 2, ... up to 5.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
         stepCycle();
         checkVal("run_pc", bus.pc, 8'(i));
      end

      // Single load-use bubble at pc=5 with full freeze.
      snap_instr   = bus.ifid_instr;
      snap_ifid_pc = bus.ifid_pc;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      stepCycle();
      checkVal("lu_pc",         bus.pc,         8'h05);
      checkVal("lu_idex_valid", bus.idex_valid, 1'b0);
      checkVal("lu_idex_ctrl",  bus.idex_ctrl,  9'h000);
      checkVal("lu_ifid_instr", bus.ifid_instr, snap_instr);
      checkVal("lu_ifid_pc",    bus.ifid_pc,    snap_ifid_pc);
      checkVal("lu_stall_cnt",  bus.stall_cnt,  16'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("lu_resume_pc", bus.pc, 8'h06);

      // Walk to pc=0x12, then branch to 0x40.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
      stepCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
         stepCycle();
      end
      checkVal("pre_br_pc", bus.pc, 8'h12);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
      stepCycle();
      checkVal("br_pc",         bus.pc,         8'h40);
      checkVal("br_ifid_valid", bus.ifid_valid, 1'b0);
      checkVal("br_idex_valid", bus.idex_valid, 1'b0);
      checkVal("br_flush_cnt",  bus.flush_cnt,  16'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("br_bubble2",    bus.idex_valid, 1'b0);
      checkVal("br_pc_adv",     bus.pc,         8'h41);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("br_refill",     bus.idex_valid, 1'b1);

      // Branch in the same cycle as a load-use request: branch wins.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
      stepCycle();
      checkVal("brnop_pc",        bus.pc,        8'h80);
      checkVal("brnop_stall_cnt", bus.stall_cnt, 16'd1);

      // Memory stall for 3 cycles mid-flush; a branch request is ignored.
      snap_pc = bus.pc;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
         stepCycle();
         checkVal("ext_pc_hold", bus.pc, snap_pc);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("ext_resume_bubble", bus.idex_valid, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("ext_resume_run", bus.idex_valid, 1'b1);

      // Watchdog: five consecutive stall cycles trip stall_err on the fifth.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         stepCycle();
         checkVal("wd_err", bus.stall_err, (i == 5) ? 1'b1 : 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("wd_sticky", bus.stall_err, 1'b1);

      // PC wrap 0xFF -> 0x00.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("wrap_ff", bus.pc, 8'hFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("wrap_00", bus.pc, 8'h00);

      // Stall counter saturation at all-ones.
      force dut.u_stall_cnt.count_q = 16'hFFFF;
      #1;
      release dut.u_stall_cnt.count_q;
      m_stall_cnt = 16'hFFFF;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      stepCycle();
      checkVal("sat_stall_cnt", bus.stall_cnt, 16'hFFFF);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 11) == 0),
                       ($urandom_range(0, 2) == 0),
                       1'($urandom), 1'($urandom), 8'($urandom));
         stepCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
